fft_bitrev_reorder: RTL
=======================

FFT_BITREV_REORDER -- requirements
Module: fft_bitrev_reorder

Interface
REQ-001 Parameter DATA_W, default `DATA_IN_WIDTH (16): width of each real and imaginary sample.
REQ-002 Parameter LOG2N, default `C2LOG_FFT_POINTS (6): log2 of FFT points; N = 2^LOG2N.
REQ-003 Ports shall be: clk  in  1  the single clock; all logic on its rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 di_en  in  1  input valid, high for N consecutive cycles per frame, from the last SDF stage.
REQ-006 di_re / di_im  in  DATA_W each  FFT result samples, bit-reversed bin order.
REQ-007 do_en  out  1  output valid.
REQ-008 do_re / do_im  out  DATA_W each  FFT result samples, natural bin order 0..N-1.

Function
REQ-009 Storage shall be two banks of N complex words (ping-pong); the writer fills one bank while the reader drains the other.
REQ-010 Write counter wcnt (LOG2N bits) shall increment on each di_en cycle; each sample is written to address bitrev(wcnt) in the current write bank.
REQ-011 Dropping di_en before wcnt reaches N-1 shall discard the partial frame: wcnt returns to 0 and the bank is not marked full.
REQ-012 When the write with wcnt = N-1 completes, the write bank shall be marked full, the write pointer shall toggle, and wcnt shall wrap to 0.
REQ-013 The reader FSM shall have two states, IDLE and READ.
REQ-014 Reader IDLE->READ: on the cycle after a bank becomes full, rcnt = 0.
REQ-015 Reader in READ: address rcnt is issued each cycle and rcnt increments.
REQ-016 Reader READ->IDLE: after rcnt = N-1, when the other bank is not full; the drained bank's full flag clears.
REQ-017 If the other bank is full when rcnt = N-1, the reader shall stay in READ, switch banks, and set rcnt to 0, so output is back-to-back with no gap.
REQ-018 RAM read shall be registered; do_en/do_re/do_im follow the read address by one cycle.
REQ-019 Latency: when the last input sample of a frame is at cycle t, do_en shall be high during cycles t+2..t+N+1.
REQ-020 Outside do_en, do_re/do_im shall be held at 0.
REQ-021 Back-to-back input frames (di_en continuous) shall produce continuous output with do_en never dropping between frames.
REQ-022 A write to a bank still being read cannot occur, because a frame takes at least N cycles; no overflow flag is required.

Reset
REQ-023 rst shall force: wcnt = 0, rcnt = 0, write pointer = bank 0, read pointer = bank 0, both full flags = 0, FSM = IDLE, do_en = 0, do_re = do_im = 0.
REQ-024 RAM contents shall not be reset.
REQ-025 rst asserted mid-frame or mid-read shall abandon all in-flight data; the first complete frame after release is handled normally.

Configuration
REQ-026 Macro REORDER_OUT_IDX_EN defined: an extra output port do_idx [LOG2N-1:0] carries the natural bin index of the current output sample, aligned with do_en and reset to 0.
REQ-027 Macro not defined: port do_idx and its register are absent; all other behaviour is identical.

Structure
REQ-028 DATA_IN_WIDTH and C2LOG_FFT_POINTS shall come from the shared define.v header.
REQ-029 A bitrev helper function of width LOG2N shall live in the same shared header.
REQ-030 One sub-module, ReorderRam: simple dual-port RAM of 2N x 2*DATA_W with a synchronous registered read port; bank select is the address MSB.

Verification (LOG2N=3, N=8)
REQ-031 One frame, di_re = bitrev(k) for k = 0..7, di_im = 7-bitrev(k) -> do_en high for 8 cycles starting 2 cycles after the last input; do_re = 0..7, do_im = 7..0.
REQ-032 Three back-to-back frames with offsets 0, 8, 16 added to di_re -> 24 contiguous do_en cycles; do_re = 0..23 in natural order.
REQ-033 di_en drops after 5 samples, then a full frame follows -> only the full frame is output; the partial frame produces no do_en.
REQ-034 rst pulsed at output sample 3 -> do_en = 0 and do_re = 0 immediately (asynchronous); the next full frame outputs correctly.
REQ-035 Frames separated by a 3-cycle di_en gap -> do_en low exactly 3 cycles between output frames; data order correct.
REQ-036 With REORDER_OUT_IDX_EN defined, rerun REQ-031 -> do_idx = 0..7 aligned with do_re.

Source files
------------

// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared header for the FFT bit-reverse reorder buffer: default widths as
// macros plus the bit-reversal helper and reader state type.
`ifndef FFT_BITREV_REORDER_DEFINES
`define FFT_BITREV_REORDER_DEFINES
`define DATA_IN_WIDTH    16
`define C2LOG_FFT_POINTS 6
`endif

package fft_bitrev_reorder_pkg;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_e;

    // Reverses the low 'width' bits of value; bits above 'width' are ignored.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned width);
        logic [31:0] rev;
        rev = {<<{value}};
        return rev >> (32 - width);
    endfunction

endpackage

// File: rtl/fft_bitrev_reorder_ram.sv
// ReorderRam: simple dual-port RAM, one write port and one registered read
// port. The caller places the ping-pong bank select in the address MSB.
module ReorderRam #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_data_q;

    // NOTE: storage and its read register carry no reset so they map onto
    // block RAM; consumers must qualify rd_data_o with their own valid.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer turning bit-reversed SDF FFT output into natural
// bin order. Define REORDER_OUT_IDX_EN to add the do_idx bin-index output.
`ifndef FFT_BITREV_REORDER_DEFINES
`define FFT_BITREV_REORDER_DEFINES
`define DATA_IN_WIDTH    16
`define C2LOG_FFT_POINTS 6
`endif

module fft_bitrev_reorder
    import fft_bitrev_reorder_pkg::*;
#(
    parameter int DATA_W = `DATA_IN_WIDTH,
    parameter int LOG2N  = `C2LOG_FFT_POINTS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              di_en,
    input  logic [DATA_W-1:0] di_re,
    input  logic [DATA_W-1:0] di_im,
    output logic              do_en,
    output logic [DATA_W-1:0] do_re,
    output logic [DATA_W-1:0] do_im
`ifdef REORDER_OUT_IDX_EN
    ,
    output logic [LOG2N-1:0]  do_idx
`endif
);

    localparam logic [LOG2N-1:0] CNT_LAST = {LOG2N{1'b1}};

    logic [LOG2N-1:0]    wcnt_q, wcnt_d;
    logic [LOG2N-1:0]    rcnt_q, rcnt_d;
    logic                wbank_q, wbank_d;
    logic                rbank_q, rbank_d;
    logic [1:0]          full_q, full_d;
    rd_state_e           state_q, state_d;
    logic                do_en_q;
    logic                wr_done, rd_issue, cur_ready, other_ready;
    logic [LOG2N-1:0]    wr_addr_rev;
    logic [2*DATA_W-1:0] rd_data;

    assign wr_done     = di_en && (wcnt_q == CNT_LAST);
    assign wr_addr_rev = LOG2N'(bitrev(32'(wcnt_q), LOG2N));
    assign wcnt_d      = di_en ? wcnt_q + 1'b1 : '0;
    assign wbank_d     = wbank_q ^ wr_done;

    // A frame completing this cycle counts as ready, so the reader starts (or
    // continues back-to-back) one cycle later instead of two.
    assign cur_ready   = full_q[rbank_q]  | (wr_done && (wbank_q == rbank_q));
    assign other_ready = full_q[~rbank_q] | (wr_done && (wbank_q != rbank_q));

    // NOTE: every output of this block is given a default first so no path
    // through the case leaves a variable unassigned and infers a latch.
    always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        rbank_d  = rbank_q;
        full_d   = full_q;
        rd_issue = 1'b0;
        if (wr_done) begin
            full_d[wbank_q] = 1'b1;
        end
        unique case (state_q)
            RD_IDLE: begin
                rcnt_d = '0;
                if (cur_ready) begin
                    state_d = RD_READ;
                end
            end
            RD_READ: begin
                rd_issue = 1'b1;
                rcnt_d   = rcnt_q + 1'b1;
                if (rcnt_q == CNT_LAST) begin
                    full_d[rbank_q] = 1'b0;
                    rbank_d         = ~rbank_q;
                    if (!other_ready) begin
                        state_d = RD_IDLE;
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its peers, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            full_q  <= '0;
            state_q <= RD_IDLE;
            do_en_q <= 1'b0;
        end else begin
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            full_q  <= full_d;
            state_q <= state_d;
            do_en_q <= rd_issue;
        end
    end

    ReorderRam #(
        .ADDR_W (LOG2N + 1),
        .DATA_W (2 * DATA_W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (di_en),
        .wr_addr_i ({wbank_q, wr_addr_rev}),
        .wr_data_i ({di_re, di_im}),
        .rd_en_i   (rd_issue),
        .rd_addr_i ({rbank_q, rcnt_q}),
        .rd_data_o (rd_data)
    );

    // Output data is masked rather than reset, so it drops to 0 with do_en.
    assign do_en = do_en_q;
    assign do_re = do_en_q ? rd_data[2*DATA_W-1:DATA_W] : '0;
    assign do_im = do_en_q ? rd_data[DATA_W-1:0]        : '0;

`ifdef REORDER_OUT_IDX_EN
    logic [LOG2N-1:0] idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= rd_issue ? rcnt_q : '0;
        end
    end

    assign do_idx = idx_q;
`endif

endmodule
